// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small receive FIFO and sticky frame/overrun error flags.
// Latency: byte enters the FIFO one clock after the stop-bit sample; backpressure via rx_valid/rx_ready, overflow drops the byte.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err,
    output logic       rx_busy
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW   = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;
    logic          armed_q, armed_d;
    logic          push_q, push_d;
    logic          fe_set;
    logic [1:0]    sync_q;
    logic          rxd_s;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [NW-1:0] count_q;
    logic          frame_err_q, overrun_q;
    logic          pop, full, wr_en, ov_set;

    assign rxd_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        armed_d = armed_q;
        push_d  = 1'b0;
        fe_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rxd_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    sr_d  = {rxd_s, sr_q[7:1]};
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxd_s) begin
                        push_d = 1'b1;
                    end else begin
                        // A held-low line must go high before the next start edge counts.
                        fe_set  = 1'b1;
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop    = rx_valid & rx_ready;
    assign full   = (count_q == NW'(FIFO_DEPTH));
    assign wr_en  = push_q & (~full | pop);
    assign ov_set = push_q & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sr_q        <= '0;
            armed_q     <= 1'b1;
            push_q      <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync_q      <= {sync_q[0], rxd};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            armed_q     <= armed_d;
            push_q      <= push_d;
            frame_err_q <= (frame_err_q & ~clr_err) | fe_set;
            overrun_q   <= (overrun_q & ~clr_err) | ov_set;
            if (wr_en) begin
                mem_q[wr_q] <= sr_q;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            if (wr_en && !pop)      count_q <= count_q + NW'(1);
            else if (!wr_en && pop) count_q <= count_q - NW'(1);
        end
    end

    assign rx_data   = mem_q[rd_q];
    assign rx_valid  = (count_q != '0);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus multi-frame, glitch, overrun and reset sequences.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       clr_err = 1'b0;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rxd = 1'b1;
        idle(8);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    vec_t vecs[5];
    int   vcnt;
    logic [7:0] vdat;
    logic seen_busy;

    initial begin
        vecs[0] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 8'h00, 1'b1};

        idle(3);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_fe", frame_err, 0);
        check("reset_ov", overrun, 0);
        check("reset_busy", rx_busy, 0);
        rst_n = 1'b1;
        idle(4);

        for (int v = 0; v < 5; v++) begin
            send_byte(vecs[v].dat, vecs[v].stop);
            check($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_valid);
            if (vecs[v].exp_valid) check($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
            check($sformatf("vec%0d_fe", v), frame_err, vecs[v].exp_fe);
            check($sformatf("vec%0d_busy", v), rx_busy, 0);
            if (rx_valid) pop_one();
            check($sformatf("vec%0d_empty", v), rx_valid, 0);
            pulse_clr();
            check($sformatf("vec%0d_fe_clr", v), frame_err, 0);
        end

        // Streaming consumer: exactly one valid cycle per byte.
        rx_ready = 1'b1;
        vcnt = 0;
        vdat = 8'h00;
        fork
            send_byte(8'h0F, 1'b1);
            for (int i = 0; i < 10 * CPB + 4; i++) begin
                @(negedge clk);
                if (rx_valid) begin
                    vcnt++;
                    vdat = rx_data;
                end
            end
        join
        rx_ready = 1'b0;
        check("stream_pulses", vcnt, 1);
        check("stream_data", vdat, 8'h0F);
        check("stream_fe", frame_err, 0);

        // Two queued bytes pop in order.
        send_byte(8'h3D, 1'b1);
        send_byte(8'h0A, 1'b1);
        check("two_head0", rx_data, 8'h3D);
        pop_one();
        check("two_valid1", rx_valid, 1);
        check("two_head1", rx_data, 8'h0A);
        pop_one();
        check("two_empty", rx_valid, 0);

        // Short start glitch is rejected.
        seen_busy = 1'b0;
        rxd = 1'b0;
        idle(CPB / 4);
        rxd = 1'b1;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clk);
            if (rx_busy) seen_busy = 1'b1;
        end
        check("glitch_saw_start", seen_busy, 1);
        check("glitch_busy", rx_busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_fe", frame_err, 0);

        // Overrun with DEPTH+1 bytes.
        for (int b = 1; b <= DEPTH + 1; b++) send_byte(8'(b), 1'b1);
        check("ovr_flag", overrun, 1);
        for (int b = 1; b <= DEPTH; b++) begin
            check($sformatf("ovr_valid%0d", b), rx_valid, 1);
            check($sformatf("ovr_data%0d", b), rx_data, b);
            pop_one();
        end
        check("ovr_empty", rx_valid, 0);
        pulse_clr();
        check("ovr_clr", overrun, 0);

        // Reset in the middle of data bit 4 with a byte already queued.
        send_byte(8'h3C, 1'b1);
        check("pre_rst_valid", rx_valid, 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rxd = 1'b1;
        idle(CPB / 2);
        check("pre_rst_busy", rx_busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_fe", frame_err, 0);
        check("rst_ov", overrun, 0);
        check("rst_busy", rx_busy, 0);
        idle(3);
        rst_n = 1'b1;
        idle(2 * CPB);
        check("post_rst_idle", rx_valid, 0);
        send_byte(8'hA5, 1'b1);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'hA5);
        check("post_rst_fe", frame_err, 0);
        pop_one();
        check("post_rst_empty", rx_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
